// File: rtl/xsz_pkg.sv
// Shared definitions for the wide-to-narrow split controller.
package xsz_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } xsz_state_t;

    // Bits needed to index n lanes (at least one).
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xsz_lane_find.sv
// Finds the lowest lane at or above a start lane whose byte strobes are not all zero.
module xsz_lane_find #(
    parameter int N  = 4,
    parameter int SW = 4,
    parameter int LW = 2
) (
    input  logic [N*SW-1:0] strb,
    input  logic [LW:0]     start,
    output logic [LW-1:0]   next,
    output logic            found,
    output logic            is_last
);

    localparam int SLW = LW + 1;

    // Scan upward: the first hit is the next lane, any later hit means it is not the last one.
    always_comb begin
        next    = '0;
        found   = 1'b0;
        is_last = 1'b1;
        for (int i = 0; i < N; i++) begin
            if ((|strb[i*SW +: SW]) && (SLW'(i) >= start)) begin
                if (found) begin
                    is_last = 1'b0;
                end else begin
                    found = 1'b1;
                    next  = LW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/xsz_split_ctrl.sv
// Splits one wide write beat into narrow beats, one per lane with active strobes,
// starting at the lane addressed by the wide beat.
module xsz_split_ctrl
    import xsz_pkg::*;
#(
    parameter int A  = 19,
    parameter int DI = 128,
    parameter int DO = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vld_s,
    output logic            rdy_s,
    input  logic [A-1:0]    adr_s,
    input  logic [DI-1:0]   dat_s,
    input  logic [DI/8-1:0] strb_s,
    output logic            vld_m,
    input  logic            rdy_m,
    output logic [A-1:0]    adr_m,
    output logic [DO-1:0]   dat_m,
    output logic [DO/8-1:0] strb_m,
    output logic            last_m
);

    localparam int N    = DI / DO;
    localparam int SW   = DO / 8;
    localparam int LIDX = $clog2(SW);
    localparam int HIDX = $clog2(DI / 8) - 1;
    localparam int LW   = lane_w(N);
    localparam logic [A-1:0] BLK_MASK = ~A'((DI / 8) - 1);

    xsz_state_t      state;
    logic [LW-1:0]   lane;
    logic [A-1:0]    adr_q;
    logic [DI-1:0]   dat_q;
    logic [DI/8-1:0] strb_q;

    logic [LW:0]     cap_start;
    logic [LW-1:0]   cap_next;
    logic            cap_found;
    logic            unused_cap_last;

    logic [LW:0]     run_start;
    logic [LW-1:0]   run_next;
    logic            run_found;
    logic            unused_run_last;

    logic            busy;
    logic            last_int;
    logic            take_s;
    logic [A-1:0]    adr_aln;

    assign cap_start = {1'b0, adr_s[HIDX:LIDX]};
    assign run_start = {1'b0, lane} + {{LW{1'b0}}, 1'b1};

    // First lane to issue for the incoming wide beat.
    xsz_lane_find #(.N(N), .SW(SW), .LW(LW)) u_find_cap (
        .strb    (strb_s),
        .start   (cap_start),
        .next    (cap_next),
        .found   (cap_found),
        .is_last (unused_cap_last)
    );

    // Following lane for the captured beat; none found means the current beat is the last.
    xsz_lane_find #(.N(N), .SW(SW), .LW(LW)) u_find_run (
        .strb    (strb_q),
        .start   (run_start),
        .next    (run_next),
        .found   (run_found),
        .is_last (unused_run_last)
    );

    assign busy     = (state == ST_SEND);
    assign last_int = ~run_found;
    assign take_s   = rdy_s & vld_s;
    assign adr_aln  = (adr_q & BLK_MASK) | (A'(lane) << LIDX);

    // Control FSM: capture a wide beat, walk its non-empty lanes, chain the next beat on the last handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            lane   <= '0;
            adr_q  <= '0;
            dat_q  <= '0;
            strb_q <= '0;
        end else if (take_s) begin
            adr_q  <= adr_s;
            dat_q  <= dat_s;
            strb_q <= strb_s;
            // An all-zero beat still issues one empty beat at its start lane.
            lane   <= cap_found ? cap_next : adr_s[HIDX:LIDX];
            state  <= ST_SEND;
        end else if (busy && rdy_m) begin
            if (last_int) begin
                state <= ST_IDLE;
            end else begin
                lane <= run_next;
            end
        end
    end

    // Master-side beat decoded from the captured beat and lane; the start lane keeps the original byte offset.
    always_comb begin
        rdy_s  = 1'b0;
        vld_m  = 1'b0;
        last_m = 1'b0;
        adr_m  = '0;
        dat_m  = '0;
        strb_m = '0;
        if (!rst) begin
            rdy_s = ~busy | (rdy_m & last_int);
            if (busy) begin
                vld_m  = 1'b1;
                last_m = last_int;
                adr_m  = (lane == adr_q[HIDX:LIDX]) ? adr_q : adr_aln;
                dat_m  = dat_q[lane*DO +: DO];
                strb_m = strb_q[lane*SW +: SW];
            end
        end
    end

endmodule

// File: tb/tb_xsz_split_ctrl.sv
// Scoreboard bench for xsz_split_ctrl: directed cases plus randomized traffic.
module tb_xsz_split_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         vld_s = 1'b0;
    logic         rdy_s;
    logic [18:0]  adr_s = '0;
    logic [127:0] dat_s = '0;
    logic [15:0]  strb_s = '0;
    logic         vld_m;
    logic         rdy_m = 1'b1;
    logic [18:0]  adr_m;
    logic [31:0]  dat_m;
    logic [3:0]   strb_m;
    logic         last_m;

    logic         vld_s2 = 1'b0;
    logic         rdy_s2;
    logic [18:0]  adr_s2 = '0;
    logic [63:0]  dat_s2 = '0;
    logic [7:0]   strb_s2 = '0;
    logic         vld_m2;
    logic         rdy_m2 = 1'b1;
    logic [18:0]  adr_m2;
    logic [31:0]  dat_m2;
    logic [3:0]   strb_m2;
    logic         last_m2;

    typedef struct {
        logic [18:0] adr;
        logic [31:0] dat;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;
    int rmode = 0;
    int pidx = 0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic        held = 1'b0;
    logic [18:0] h_adr;
    logic [31:0] h_dat;
    logic [3:0]  h_strb;
    logic        h_last;

    xsz_split_ctrl #(.A(19), .DI(128), .DO(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .vld_s  (vld_s),
        .rdy_s  (rdy_s),
        .adr_s  (adr_s),
        .dat_s  (dat_s),
        .strb_s (strb_s),
        .vld_m  (vld_m),
        .rdy_m  (rdy_m),
        .adr_m  (adr_m),
        .dat_m  (dat_m),
        .strb_m (strb_m),
        .last_m (last_m)
    );

    xsz_split_ctrl #(.A(19), .DI(64), .DO(32)) dut64 (
        .clk    (clk),
        .rst    (rst),
        .vld_s  (vld_s2),
        .rdy_s  (rdy_s2),
        .adr_s  (adr_s2),
        .dat_s  (dat_s2),
        .strb_s (strb_s2),
        .vld_m  (vld_m2),
        .rdy_m  (rdy_m2),
        .adr_m  (adr_m2),
        .dat_m  (dat_m2),
        .strb_m (strb_m2),
        .last_m (last_m2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", nm);
    endtask

    task automatic push_beat(input logic [18:0] a, input logic [31:0] d, input logic [3:0] s, input logic l);
        beat_t b;
        b.adr = a; b.dat = d; b.strb = s; b.last = l;
        exp_q.push_back(b);
    endtask

    // Reference: list the lanes from the addressed lane upward that carry any strobe.
    task automatic model_push(input logic [18:0] a, input logic [127:0] d, input logic [15:0] s);
        int l0;
        int lanes[$];
        logic [18:0] ba;
        l0 = int'((a >> 2) & 19'h3);
        for (int l = l0; l < 4; l++)
            if (s[l*4 +: 4] != 4'h0) lanes.push_back(l);
        if (lanes.size() == 0) begin
            push_beat(a, d[l0*32 +: 32], 4'h0, 1'b1);
        end else begin
            for (int k = 0; k < lanes.size(); k++) begin
                ba = (lanes[k] == l0) ? a : ((a & 19'h7FFF0) | 19'(lanes[k] * 4));
                push_beat(ba, d[lanes[k]*32 +: 32], s[lanes[k]*4 +: 4], k == lanes.size() - 1);
            end
        end
    endtask

    // Offer a wide beat, wait for acceptance, then expect a narrow beat on the next cycle.
    task automatic send(input logic [18:0] a, input logic [127:0] d, input logic [15:0] s, input bit use_model);
        int k;
        vld_s = 1'b1; adr_s = a; dat_s = d; strb_s = s;
        k = 0;
        @(negedge clk);
        while (!rdy_s && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (!rdy_s) begin
            fail("rdy_s_timeout");
            vld_s = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        vld_s = 1'b0;
        chk("first_beat_latency", vld_m, 1'b1);
        if (use_model) model_push(a, d, s);
    endtask

    // Master-side ready generator.
    always @(posedge clk) begin
        #2;
        case (rmode)
            1: rdy_m = 1'($urandom_range(0, 1));
            2: begin
                rdy_m = pat[pidx];
                pidx = (pidx + 1) % 4;
            end
            default: rdy_m = 1'b1;
        endcase
    end

    // Monitor: scoreboard pops, hold stability, no bubbles, rdy_s only on last handshake.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_vld", vld_m, 1'b1);
                chk("hold_adr", adr_m, h_adr);
                chk("hold_dat", dat_m, h_dat);
                chk("hold_strb", strb_m, h_strb);
                chk("hold_last", last_m, h_last);
            end
            if (exp_q.size() > 0) chk("no_bubble", vld_m, 1'b1);
            if (rdy_s && vld_m) chk("rdy_s_only_on_last", {rdy_m, last_m}, 2'b11);
            if (vld_m && rdy_m) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_beat");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_adr", adr_m, mon_e.adr);
                    chk("beat_dat", dat_m, mon_e.dat);
                    chk("beat_strb", strb_m, mon_e.strb);
                    chk("beat_last", last_m, mon_e.last);
                end
            end
            held   = vld_m && !rdy_m;
            h_adr  = adr_m;
            h_dat  = dat_m;
            h_strb = strb_m;
            h_last = last_m;
        end
    end

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (exp_q.size() > 0) begin
            fail("drain_timeout");
            exp_q.delete();
        end
    endtask

    localparam logic [127:0] DD = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};

    initial begin
        logic [127:0] rd;
        logic [15:0]  rs;
        int           gap;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld_m", vld_m, 1'b0);
        chk("rst_rdy_s", rdy_s, 1'b0);
        chk("rst_last_m", last_m, 1'b0);
        chk("rst_adr_m", adr_m, 19'h0);
        chk("rst_dat_m", dat_m, 32'h0);
        chk("rst_strb_m", strb_m, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rdy_s", rdy_s, 1'b1);
        chk("idle_vld_m", vld_m, 1'b0);
        @(posedge clk);
        #1;

        // Full beat at lane 0
        rmode = 0;
        send(19'h100, DD, 16'hFFFF, 1'b0);
        push_beat(19'h100, 32'hD0D0D0D0, 4'hF, 1'b0);
        push_beat(19'h104, 32'hD1D1D1D1, 4'hF, 1'b0);
        push_beat(19'h108, 32'hD2D2D2D2, 4'hF, 1'b0);
        push_beat(19'h10C, 32'hD3D3D3D3, 4'hF, 1'b1);
        drain();

        // Unaligned start, partial first lane
        send(19'h106, DD, 16'hFFC0, 1'b0);
        push_beat(19'h106, 32'hD1D1D1D1, 4'hC, 1'b0);
        push_beat(19'h108, 32'hD2D2D2D2, 4'hF, 1'b0);
        push_beat(19'h10C, 32'hD3D3D3D3, 4'hF, 1'b1);
        drain();

        // Skipped empty lanes, then an all-empty beat
        send(19'h200, DD, 16'hF00F, 1'b0);
        push_beat(19'h200, 32'hD0D0D0D0, 4'hF, 1'b0);
        push_beat(19'h20C, 32'hD3D3D3D3, 4'hF, 1'b1);
        drain();
        send(19'h200, DD, 16'h0000, 1'b0);
        push_beat(19'h200, 32'hD0D0D0D0, 4'h0, 1'b1);
        drain();

        // Stall pattern with back-to-back wide beats
        @(posedge clk);
        #1;
        pidx = 0;
        rmode = 2;
        send(19'h300, DD, 16'hFFFF, 1'b0);
        push_beat(19'h300, 32'hD0D0D0D0, 4'hF, 1'b0);
        push_beat(19'h304, 32'hD1D1D1D1, 4'hF, 1'b0);
        push_beat(19'h308, 32'hD2D2D2D2, 4'hF, 1'b0);
        push_beat(19'h30C, 32'hD3D3D3D3, 4'hF, 1'b1);
        send(19'h408, DD, 16'hFF00, 1'b0);
        push_beat(19'h408, 32'hD2D2D2D2, 4'hF, 1'b0);
        push_beat(19'h40C, 32'hD3D3D3D3, 4'hF, 1'b1);
        drain();
        rmode = 0;

        // Reset while the second narrow beat is pending
        @(posedge clk);
        #1;
        send(19'h100, DD, 16'hFFFF, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("rst_mid_vld_m", vld_m, 1'b0);
        chk("rst_mid_rdy_s", rdy_s, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_vld_m", vld_m, 1'b0);
        chk("post_rst_rdy_s", rdy_s, 1'b1);
        send(19'h100, DD, 16'hFFFF, 1'b1);
        drain();

        // Randomized traffic with random master backpressure
        rmode = 1;
        for (int t = 0; t < 200; t++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            for (int l = 0; l < 4; l++)
                rs[l*4 +: 4] = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom);
            send(19'($urandom), rd, rs, 1'b1);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rmode = 0;

        // Two-lane variant: start at the upper lane gives a single last beat
        @(posedge clk);
        #1;
        vld_s2 = 1'b1;
        adr_s2 = 19'h4;
        dat_s2 = {32'hBBBB0001, 32'hAAAA0000};
        strb_s2 = 8'hF0;
        @(negedge clk);
        chk("n2_rdy_s", rdy_s2, 1'b1);
        @(posedge clk);
        #1;
        vld_s2 = 1'b0;
        chk("n2_vld_m", vld_m2, 1'b1);
        chk("n2_adr_m", adr_m2, 19'h4);
        chk("n2_dat_m", dat_m2, 32'hBBBB0001);
        chk("n2_strb_m", strb_m2, 4'hF);
        chk("n2_last_m", last_m2, 1'b1);
        @(posedge clk);
        #1;
        chk("n2_done_vld_m", vld_m2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xsz_split_ctrl.md
XSZ_SPLIT_CTRL -- requirements
Module: xsz_split_ctrl

Interface
REQ-001 SHALL have parameter A, default 19, address width.
REQ-002 SHALL have parameter DI, default 128, slave-side (wide) data width in bits; power of two, DI > DO.
REQ-003 SHALL have parameter DO, default 32, master-side (narrow) data width in bits; power of two, DO >= 8.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports vld_s input 1 / rdy_s output 1: slave-side wide-beat handshake.
REQ-007 SHALL have ports adr_s input A, dat_s input DI, strb_s input DI/8: wide-beat address, data, byte strobes.
REQ-008 SHALL have ports vld_m output 1 / rdy_m input 1: master-side narrow-beat handshake.
REQ-009 SHALL have ports adr_m output A, dat_m output DO, strb_m output DO/8, last_m output 1: narrow-beat address, data, strobes, final-beat flag.

Function
REQ-010 SHALL define N = DI/DO lanes, LIDX = log2(DO/8), HIDX = log2(DI/8)-1; lane index of an address = adr[HIDX:LIDX].
REQ-011 SHALL implement FSM states IDLE and SEND.
REQ-012 SHALL, in IDLE, drive rdy_s=1 and vld_m=0; on vld_s&rdy_s capture adr_s, dat_s, strb_s and go to SEND.
REQ-013 SHALL issue the first narrow beat in the cycle after capture (1-cycle latency, vld_m=1 at T+1).
REQ-014 SHALL start at lane L0 = lane index of captured address and visit lanes L0..N-1 in increasing order; lanes below L0 are never issued.
REQ-015 SHALL skip any lane whose DO/8 strobe bits are all zero, advancing to the next non-zero lane in one cycle (no bubble).
REQ-016 SHALL, if all strobes of lanes L0..N-1 are zero, issue exactly one beat at lane L0 with strb_m=0 and last_m=1.
REQ-017 SHALL drive dat_m/strb_m = captured dat/strb slice for the current lane.
REQ-018 SHALL drive adr_m = captured address for the first issued beat, and for later beats captured address with bits [HIDX:LIDX] = lane and bits [LIDX-1:0] = 0.
REQ-019 SHALL assert last_m on the beat with no further non-zero-strobe lane above it.
REQ-020 SHALL hold vld_m, adr_m, dat_m, strb_m, last_m stable while vld_m=1 and rdy_m=0.
REQ-021 SHALL advance lane only on vld_m&rdy_m.
REQ-022 SHALL drive rdy_s = IDLE | (SEND & vld_m & rdy_m & last_m); a wide beat accepted in that cycle is captured and SEND continues with no idle cycle.
REQ-023 SHALL return to IDLE after the last-beat handshake when vld_s=0 in that cycle.
REQ-024 SHALL never present vld_m=1 in IDLE, and never change state on vld_s while SEND and not completing the last beat.

Reset
REQ-025 SHALL, with rst=1 at a clock edge, enter IDLE, clear lane counter and capture registers; outputs: vld_m=0, last_m=0, adr_m=0, dat_m=0, strb_m=0, rdy_s=0 while rst=1.
REQ-026 SHALL abandon any in-progress wide beat on reset mid-SEND without issuing remaining beats; first handshake allowed the cycle after rst deasserts.

Structure
REQ-027 SHALL place FSM state enum and lane-index width helper in a shared package xsz_pkg.
REQ-028 SHALL use one sub-module xsz_lane_find: combinational next-non-zero-lane finder (strobe mask, start lane -> next lane, found, is_last).
REQ-029 SHALL contain no storage beyond one wide-beat capture register, lane counter and state.

Verification (DI=128, DO=32, A=19 unless noted)
REQ-030 SHALL check adr_s=0x100, strb_s=0xFFFF, rdy_m=1 -> 4 beats adr_m 0x100,0x104,0x108,0x10C, last_m on 4th, first at T+1.
REQ-031 SHALL check adr_s=0x106, strb_s=0xFFC0 -> beats adr_m 0x106 (strb 0xC), 0x108, 0x10C; last_m on 0x10C; lanes 0 never issued.
REQ-032 SHALL check strb_s=0xF00F at adr 0x200 -> beats 0x200, 0x20C only, no bubble between; strb_s=0x0000 -> single beat adr 0x200, strb_m=0, last_m=1.
REQ-033 SHALL check rdy_m toggling 1,0,0,1 -> master outputs stable during stalls; back-to-back vld_s -> rdy_s=1 only in last-beat handshake cycle, next beat's first lane at following cycle.
REQ-034 SHALL check rst pulsed during 2nd beat -> vld_m=0 next cycle, IDLE, new wide beat accepted after deassert with correct 4-beat sequence.
REQ-035 SHALL check DI=64, DO=32 with adr_s=0x4 -> single beat adr 0x4, last_m=1.
